seven_segment_scan_decoder: RTL
===============================

Name: seven_segment_scan_decoder

Overview:
- Receive side of the multiplexed seven-segment display interface.
- Samples the active-low segment bus and active-low digit strobes, qualifies each digit after a settle period, and decodes each pattern back to a hex nibble.
- Publishes a multi-digit value only after several identical complete scans.
- Used as a bench/loopback monitor and as the readback path for display-driven status.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SETTLE_CYCLES, 2, consecutive identical samples required before a digit is captured (>=1).
- STABLE_SCANS, 2, consecutive identical complete frames required before value updates (>=1).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset_L  input  1  synchronous active-low reset.
- seg_n  input  7  segment lines, active-low; bit0=a ... bit6=g.
- an_n  input  NUM_DIGITS  digit strobes, active-low; bit k low selects digit k.
- value  output  4*NUM_DIGITS  last published frame; digit k at value[4k+3:4k].
- value_valid  output  1  one-cycle pulse when value is updated.
- seg_error  output  1  one-cycle pulse when a captured pattern is not a legal hex glyph.
- error_digit  output  $clog2(NUM_DIGITS)  digit index of the most recent seg_error.

Behaviour:
- One clock. Reset is synchronous and active-low (reset_L sampled on clock rising edge).
- Reset, including mid-operation, clears all state:
  - Outputs: value=0, value_valid=0, seg_error=0, error_digit=0.
  - Internal: FSM=SEEK, settle count=0, seen mask=0, frame/prev-frame=0, prev_valid=0, match count=0, published=0.
- Legal strobe: exactly one an_n bit low. Zero or multiple bits low = illegal strobe.
- Decode table (seg_n to nibble):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern, including blank 1111111, is illegal.
- FSM states SEEK, SETTLE, HOLD. "Sample" means the (digit index, seg_n) pair this cycle.
  - SEEK:
    - Legal strobe: latch sample, cnt=1, go SETTLE.
    - Otherwise: stay.
  - SETTLE:
    - Sample equals latched pair: cnt++. When cnt reaches SETTLE_CYCLES, perform capture and go HOLD.
    - Sample differs and strobe legal: re-latch, cnt=1, stay SETTLE.
    - Strobe illegal: go SEEK.
  - HOLD:
    - Sample unchanged: stay, no further capture.
    - Sample changed and strobe legal: re-latch, cnt=1, go SETTLE.
    - Strobe illegal: go SEEK.
  - SETTLE_CYCLES=1: a legal strobe in SEEK captures on that same edge and goes directly to HOLD.
- Capture, on the edge completing settle:
  - Legal glyph: frame[d]=nibble, seen[d]=1. A re-capture of an already-seen digit overwrites with no error.
  - Illegal glyph: seg_error=1 for one cycle, error_digit=d, seen cleared (frame discarded); prev-frame and match count are untouched.
- Frame completion, when a capture makes seen all ones (same edge):
  - If prev_valid and frame==prev_frame: match count++ (saturating at STABLE_SCANS). Else match count=1.
  - Then prev_frame=frame, prev_valid=1, seen=0.
  - If match count (after update) equals STABLE_SCANS and (frame!=value or published==0): value=frame, value_valid=1 for one cycle, published=1.
- Latency: value/value_valid are visible the cycle after the final settle sample of the completing digit.
- No pulse is emitted for repeated identical stable frames.
- seg_error and value_valid can pulse in the same cycle only if different edges; never both from one capture.

Test Plan:
- Reset, then scan digits 0..3 = F,3,A,1 (seg_n 0001110, 0110000, 0001000, 1111001), 3 cycles each, two full scans:
  - value=16'h1A3F with value_valid pulsing once, one cycle after the last settle of scan 2.
  - A third identical scan produces no pulse.
- Change digit 2 to 5 (0010010) for two scans:
  - value becomes 16'h153F with a single value_valid pulse.
  - No pulse after the first changed scan.
- Drive digit 1 with blank 1111111 mid-scan:
  - seg_error pulses once with error_digit=1.
  - value holds 16'h153F.
  - Two subsequent clean scans publish normally.
- Hold each digit only 1 cycle (SETTLE_CYCLES=2), and glitch seg_n for one cycle within a 3-cycle digit window:
  - No captures from 1-cycle holds; glitched digit restarts settle.
  - No value_valid until windows are clean.
- an_n=4'b1111 and 4'b0101 between digits: FSM returns to SEEK, no capture, no error.
- Assert reset_L=0 for one cycle after the second digit of a scan that would otherwise publish 16'hBEEF:
  - All outputs 0.
  - Two full scans after release are required before value=16'hBEEF.

Source files
------------

// File: rtl/seven_segment_scan_decoder.sv
// Seven-segment scan receiver: samples multiplexed digit strobes/segments,
// settles, decodes glyphs to nibbles and publishes stable multi-digit frames.
//
// Ports:
//   clock        rising-edge clock
//   reset_L      synchronous active-low reset
//   seg_n[6:0]   active-low segments, bit0=a .. bit6=g
//   an_n[N-1:0]  active-low digit strobes, exactly one low is a legal strobe
//   value        last published frame, digit k at value[4k+3:4k]
//   value_valid  one-cycle pulse when value updates
//   seg_error    one-cycle pulse on a captured non-hex pattern
//   error_digit  digit index of the most recent seg_error
module seven_segment_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STABLE_SCANS  = 2
) (
  input  logic                          clock,
  input  logic                          reset_L,
  input  logic [6:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         an_n,
  output logic [4*NUM_DIGITS-1:0]       value,
  output logic                          value_valid,
  output logic                          seg_error,
  output logic [$clog2(NUM_DIGITS)-1:0] error_digit
);

  localparam int DW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(STABLE_SCANS + 1);
  localparam int FW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] SETTLE_N = CW'(SETTLE_CYCLES);
  localparam logic [MW-1:0] STABLE_N = MW'(STABLE_SCANS);

  typedef enum logic [1:0] {
    SEEK,
    SETTLE,
    HOLD
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] lat_idx;
  logic [6:0]    lat_seg;
  logic          relatch;
  logic          capture;

  logic [FW-1:0]         frame;
  logic [FW-1:0]         prev_frame;
  logic                  prev_valid;
  logic [NUM_DIGITS-1:0] seen;
  logic [MW-1:0]         match;
  logic                  published;

  logic          legal;
  logic [DW-1:0] idx;
  logic          same;

  function automatic logic [4:0] decode(input logic [6:0] s);
    unique case (s)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0010000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = 5'h00;
    endcase
  endfunction

  // Strobe is legal only when exactly one digit line is low.
  always_comb begin
    int lows;
    lows = 0;
    idx  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!an_n[k]) begin
        lows = lows + 1;
        idx  = DW'(k);
      end
    end
    legal = (lows == 1);
  end

  assign same = (idx == lat_idx) && (seg_n == lat_seg);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    relatch   = 1'b0;
    capture   = 1'b0;
    unique case (state)
      SEEK: begin
        if (legal) begin
          relatch = 1'b1;
          cnt_nxt = CW'(1);
          if (SETTLE_CYCLES == 1) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!legal) begin
          state_nxt = SEEK;
        end else if (same) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == SETTLE_N) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else begin
          relatch = 1'b1;
          cnt_nxt = CW'(1);
        end
      end
      HOLD: begin
        if (!legal) begin
          state_nxt = SEEK;
        end else if (!same) begin
          relatch = 1'b1;
          cnt_nxt = CW'(1);
          // A one-sample settle captures the new pair immediately.
          if (SETTLE_CYCLES == 1) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      default: state_nxt = SEEK;
    endcase
  end

  // Capture datapath; capture only fires when the current sample is the
  // one being captured, so idx/seg_n address and supply the digit.
  logic [4:0]            dec;
  logic [FW-1:0]         frame_upd;
  logic [NUM_DIGITS-1:0] seen_upd;
  logic                  full;
  logic                  eq_prev;
  logic [MW-1:0]         match_upd;

  assign dec = decode(seg_n);

  always_comb begin
    frame_upd = frame;
    frame_upd[4*idx +: 4] = dec[3:0];
    seen_upd = seen | (NUM_DIGITS'(1) << idx);
    full     = &seen_upd;
    eq_prev  = prev_valid && (frame_upd == prev_frame);
    if (!eq_prev)
      match_upd = MW'(1);
    else if (match == STABLE_N)
      match_upd = match;
    else
      match_upd = match + MW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state       <= SEEK;
      cnt         <= '0;
      lat_idx     <= '0;
      lat_seg     <= '0;
      frame       <= '0;
      prev_frame  <= '0;
      prev_valid  <= 1'b0;
      seen        <= '0;
      match       <= '0;
      published   <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
      seg_error   <= 1'b0;
      error_digit <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      value_valid <= 1'b0;
      seg_error   <= 1'b0;
      if (relatch) begin
        lat_idx <= idx;
        lat_seg <= seg_n;
      end
      if (capture) begin
        if (!dec[4]) begin
          // Bad glyph discards the partial frame only.
          seg_error   <= 1'b1;
          error_digit <= idx;
          seen        <= '0;
        end else if (!full) begin
          frame <= frame_upd;
          seen  <= seen_upd;
        end else begin
          frame      <= frame_upd;
          seen       <= '0;
          prev_frame <= frame_upd;
          prev_valid <= 1'b1;
          match      <= match_upd;
          if (match_upd == STABLE_N &&
              (frame_upd != value || !published)) begin
            value       <= frame_upd;
            value_valid <= 1'b1;
            published   <= 1'b1;
          end
        end
      end
    end
  end

endmodule
